// File: rtl/huffman_seq_ctrl.sv
// Job-level sequencer for the Huffman encoder pipeline.
// Runs symbol count, tree build, code-table generation and encode in order, with a
// per-stage timeout watchdog, and reports status and job length to the host.
//
// Ports:
//   Clk_in, n_Rst          clock and synchronous active-low reset
//   Job_start, Job_abort   host job request / abort
//   Cnt_start, Cnt_done    symbol counter handshake
//   Tree_start, Tree_done  tree builder handshake
//   Cg_rst_n, Start_code   code generator local reset and start (falling edge arms)
//   Fin                    code generator finished (level)
//   Enc_start, Enc_done    encoder handshake
//   Busy, Done, Err        host status (Done one-cycle pulse, Err sticky)
//   Err_stage, Stage       state code at timeout / current state code
//   Job_cycles             length of the last completed job, saturating
module huffman_seq_ctrl #(
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 4095,
  parameter int unsigned START_W = 2
) (
  input  logic        Clk_in,
  input  logic        n_Rst,
  input  logic        Job_start,
  input  logic        Job_abort,
  output logic        Cnt_start,
  input  logic        Cnt_done,
  output logic        Tree_start,
  input  logic        Tree_done,
  output logic        Cg_rst_n,
  output logic        Start_code,
  input  logic        Fin,
  output logic        Enc_start,
  input  logic        Enc_done,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  Err_stage,
  output logic [2:0]  Stage,
  output logic [15:0] Job_cycles
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCnt     = 3'd1,
    StTree    = 3'd2,
    StCgRst   = 3'd3,
    StCgStart = 3'd4,
    StCgWait  = 3'd5,
    StEnc     = 3'd6,
    StDone    = 3'd7
  } state_e;

  // The last in-state cycle on which a stage may still see its done.
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYC - 1);
  localparam logic [2:0]       ScLast  = 3'(START_W - 1);

  state_e            state_q, state_d;
  logic              first_q, first_d;   // high on the entry cycle of a state
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        sc_q, sc_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              timeout, abort, accept, tmo_hit;

  assign Stage   = state_q;
  assign tmo_hit = (tmo_q == TmoLast);
  assign abort   = Job_abort && (state_q != StIdle);
  assign accept  = (state_q == StIdle) && Job_start && !Job_abort;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCnt;
      StCnt: begin
        // Done on the entry cycle is stale; it wins over a same-cycle timeout.
        if (!first_q && Cnt_done) state_d = StTree;
        else if (tmo_hit)         timeout = 1'b1;
      end
      StTree: begin
        if (!first_q && Tree_done) state_d = StCgRst;
        else if (tmo_hit)          timeout = 1'b1;
      end
      StCgRst:   state_d = StCgStart;
      StCgStart: if (sc_q == ScLast) state_d = StCgWait;
      StCgWait: begin
        if (Fin)          state_d = StEnc;
        else if (tmo_hit) timeout = 1'b1;
      end
      StEnc: begin
        if (!first_q && Enc_done) state_d = StDone;
        else if (tmo_hit)         timeout = 1'b1;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort) timeout = 1'b0;
    if (timeout || abort) state_d = StIdle;
  end

  always_comb begin
    first_d = (state_d != state_q);
    tmo_d   = tmo_q;
    sc_d    = sc_q;
    cyc_d   = cyc_q;
    if (state_d != state_q) begin
      tmo_d = '0;
      sc_d  = '0;
    end else begin
      if (state_q inside {StCnt, StTree, StCgWait, StEnc}) tmo_d = tmo_q + 1'b1;
      if (state_q == StCgStart) sc_d = sc_q + 1'b1;
    end
    if (accept) begin
      cyc_d = 16'd1;
    end else if ((state_q != StIdle) && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (!n_Rst) begin
      state_q    <= StIdle;
      first_q    <= 1'b0;
      tmo_q      <= '0;
      sc_q       <= '0;
      cyc_q      <= '0;
      Cnt_start  <= 1'b0;
      Tree_start <= 1'b0;
      Enc_start  <= 1'b0;
      Start_code <= 1'b0;
      Cg_rst_n   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Err_stage  <= '0;
      Job_cycles <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      tmo_q      <= tmo_d;
      sc_q       <= sc_d;
      cyc_q      <= cyc_d;
      Cnt_start  <= (state_d == StCnt)  && (state_q == StIdle);
      Tree_start <= (state_d == StTree) && (state_q == StCnt);
      Enc_start  <= (state_d == StEnc)  && (state_q == StCgWait);
      Start_code <= (state_d == StCgStart);
      // Generator is held in reset to reload tree nodes, and also flushed on abort.
      Cg_rst_n   <= !((state_d == StCgRst) || abort);
      Busy       <= (state_d != StIdle);
      Done       <= (state_d == StDone);
      if (accept) begin
        Err       <= 1'b0;
        Err_stage <= '0;
      end else if (timeout) begin
        Err       <= 1'b1;
        Err_stage <= state_q;
      end
      // Latched on DONE entry so the count, including the DONE cycle, lines up with Done.
      if ((state_d == StDone) && (state_q == StEnc)) begin
        Job_cycles <= (cyc_q == 16'hFFFF) ? 16'hFFFF : cyc_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Directed testbench for huffman_seq_ctrl (TMO_CYC=8, START_W=2).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_huffman_seq_ctrl;

  logic        Clk_in, n_Rst, Job_start, Job_abort;
  logic        Cnt_start, Cnt_done, Tree_start, Tree_done;
  logic        Cg_rst_n, Start_code, Fin, Enc_start, Enc_done;
  logic        Busy, Done, Err;
  logic [2:0]  Err_stage, Stage;
  logic [15:0] Job_cycles;

  int checks = 0;
  int errors = 0;

  huffman_seq_ctrl #(
    .TMO_W   (16),
    .TMO_CYC (8),
    .START_W (2)
  ) dut (
    .Clk_in     (Clk_in),
    .n_Rst      (n_Rst),
    .Job_start  (Job_start),
    .Job_abort  (Job_abort),
    .Cnt_start  (Cnt_start),
    .Cnt_done   (Cnt_done),
    .Tree_start (Tree_start),
    .Tree_done  (Tree_done),
    .Cg_rst_n   (Cg_rst_n),
    .Start_code (Start_code),
    .Fin        (Fin),
    .Enc_start  (Enc_start),
    .Enc_done   (Enc_done),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err),
    .Err_stage  (Err_stage),
    .Stage      (Stage),
    .Job_cycles (Job_cycles)
  );

  initial Clk_in = 1'b0;
  always #5 Clk_in = ~Clk_in;

  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // From IDLE: start a job and take it to CG_WAIT (job cycle 8) without asserting Fin.
  task automatic to_cg_wait();
    Job_start = 1'b1; tick(); Job_start = 1'b0;   // cycle 1 CNT
    tick(); Cnt_done = 1'b1;                        // cycle 2
    tick(); Cnt_done = 1'b0;                        // cycle 3 TREE
    tick(); Tree_done = 1'b1;                       // cycle 4
    tick(); Tree_done = 1'b0;                       // cycle 5 CG_RST
    tick(); tick(); tick();                         // cycle 8 CG_WAIT
    chk("front_stage", 16'(Stage), 16'd5);
  endtask

  initial begin
    n_Rst = 1'b0; Job_start = 1'b0; Job_abort = 1'b0;
    Cnt_done = 1'b0; Tree_done = 1'b0; Fin = 1'b0; Enc_done = 1'b0;
    tick(); tick();
    chk("rst_stage", 16'(Stage), 16'd0);
    chk("rst_cg_rst_n", 16'(Cg_rst_n), 16'd0);
    chk("rst_busy", 16'(Busy), 16'd0);
    chk("rst_job_cycles", Job_cycles, 16'd0);
    n_Rst = 1'b1; tick();
    chk("rst_rel_cg_rst_n", 16'(Cg_rst_n), 16'd1);

    // Nominal job, with stray inputs mixed in. Cycle k = k edges after Job_start.
    Job_start = 1'b1; tick(); Job_start = 1'b0;      // cycle 1
    chk("nom_c1_stage", 16'(Stage), 16'd1);
    chk("nom_c1_cnt_start", 16'(Cnt_start), 16'd1);
    chk("nom_c1_busy", 16'(Busy), 16'd1);
    Cnt_done = 1'b1;                                  // on the Cnt_start cycle: ignored
    tick(); Cnt_done = 1'b0;                          // cycle 2
    chk("nom_c2_stage", 16'(Stage), 16'd1);
    chk("nom_c2_cnt_start", 16'(Cnt_start), 16'd0);
    tick(); Tree_done = 1'b1;                         // cycle 3, stray Tree_done in CNT
    tick(); Tree_done = 1'b0;                         // cycle 4
    chk("nom_c4_stage", 16'(Stage), 16'd1);
    tick(); Cnt_done = 1'b1;                          // cycle 5
    tick(); Cnt_done = 1'b0;                          // cycle 6
    chk("nom_c6_stage", 16'(Stage), 16'd2);
    chk("nom_c6_tree_start", 16'(Tree_start), 16'd1);
    tick();                                           // cycle 7
    chk("nom_c7_stage", 16'(Stage), 16'd2);
    chk("nom_c7_tree_start", 16'(Tree_start), 16'd0);
    tick(); tick(); Tree_done = 1'b1;                 // cycle 9
    tick(); Tree_done = 1'b0;                         // cycle 10
    chk("nom_c10_stage", 16'(Stage), 16'd3);
    chk("nom_c10_cg_rst_n", 16'(Cg_rst_n), 16'd0);
    tick();                                           // cycle 11
    chk("nom_c11_stage", 16'(Stage), 16'd4);
    chk("nom_c11_cg_rst_n", 16'(Cg_rst_n), 16'd1);
    chk("nom_c11_start_code", 16'(Start_code), 16'd1);
    Fin = 1'b1;                                       // ignored in CG_START
    tick(); Fin = 1'b0;                               // cycle 12
    chk("nom_c12_stage", 16'(Stage), 16'd4);
    chk("nom_c12_start_code", 16'(Start_code), 16'd1);
    tick();                                           // cycle 13, Start_code falls
    chk("nom_c13_stage", 16'(Stage), 16'd5);
    chk("nom_c13_start_code", 16'(Start_code), 16'd0);
    tick(); tick(); Fin = 1'b1;                       // cycle 15
    tick(); Fin = 1'b0;                               // cycle 16
    chk("nom_c16_stage", 16'(Stage), 16'd6);
    chk("nom_c16_enc_start", 16'(Enc_start), 16'd1);
    tick(); Job_start = 1'b1;                         // cycle 17, ignored outside IDLE
    tick(); Job_start = 1'b0;                         // cycle 18
    chk("nom_c18_stage", 16'(Stage), 16'd6);
    chk("nom_c18_enc_start", 16'(Enc_start), 16'd0);
    tick(); tick(); Enc_done = 1'b1;                  // cycle 20
    chk("nom_c20_done", 16'(Done), 16'd0);
    tick(); Enc_done = 1'b0;                          // cycle 21
    chk("nom_c21_stage", 16'(Stage), 16'd7);
    chk("nom_c21_done", 16'(Done), 16'd1);
    chk("nom_c21_job_cycles", Job_cycles, 16'd21);
    chk("nom_c21_busy", 16'(Busy), 16'd1);
    tick();                                           // cycle 22
    chk("nom_c22_stage", 16'(Stage), 16'd0);
    chk("nom_c22_done", 16'(Done), 16'd0);
    chk("nom_c22_busy", 16'(Busy), 16'd0);
    chk("nom_c22_err", 16'(Err), 16'd0);

    // Timeout in TREE: entry at cycle 3, eight cycles in TREE, IDLE at cycle 11.
    Job_start = 1'b1; tick(); Job_start = 1'b0;      // cycle 1
    tick(); Cnt_done = 1'b1;                          // cycle 2
    tick(); Cnt_done = 1'b0;                          // cycle 3 TREE
    for (int i = 0; i < 7; i++) tick();               // cycle 10
    chk("tmo_c10_stage", 16'(Stage), 16'd2);
    chk("tmo_c10_err", 16'(Err), 16'd0);
    tick();                                           // cycle 11
    chk("tmo_c11_stage", 16'(Stage), 16'd0);
    chk("tmo_c11_err", 16'(Err), 16'd1);
    chk("tmo_c11_err_stage", 16'(Err_stage), 16'd2);
    chk("tmo_c11_done", 16'(Done), 16'd0);
    chk("tmo_c11_job_cycles", Job_cycles, 16'd21);
    tick();
    chk("tmo_sticky_err", 16'(Err), 16'd1);

    // Next job clears Err; abort it in CG_WAIT.
    to_cg_wait();
    chk("abt_err_cleared", 16'(Err), 16'd0);
    chk("abt_err_stage_cleared", 16'(Err_stage), 16'd0);
    Job_abort = 1'b1; tick(); Job_abort = 1'b0;
    chk("abt_stage", 16'(Stage), 16'd0);
    chk("abt_cg_rst_n", 16'(Cg_rst_n), 16'd0);
    chk("abt_busy", 16'(Busy), 16'd0);
    chk("abt_done", 16'(Done), 16'd0);
    chk("abt_err", 16'(Err), 16'd0);
    Fin = 1'b1; tick(); Fin = 1'b0;
    chk("abt_cg_rst_n_rel", 16'(Cg_rst_n), 16'd1);
    chk("abt_fin_stage", 16'(Stage), 16'd0);
    tick();
    chk("abt_fin_stage2", 16'(Stage), 16'd0);

    // Abort in IDLE blocks a simultaneous Job_start.
    Job_start = 1'b1; Job_abort = 1'b1; tick();
    Job_start = 1'b0; Job_abort = 1'b0;
    chk("idle_abort_stage", 16'(Stage), 16'd0);
    chk("idle_abort_cg_rst_n", 16'(Cg_rst_n), 16'd1);

    // Enc_done on the last watchdog cycle: ENC entry cycle 9, last cycle 16.
    to_cg_wait();
    Fin = 1'b1; tick(); Fin = 1'b0;                   // cycle 9 ENC
    chk("edge_c9_stage", 16'(Stage), 16'd6);
    for (int i = 0; i < 7; i++) tick();               // cycle 16
    chk("edge_c16_stage", 16'(Stage), 16'd6);
    Enc_done = 1'b1; tick(); Enc_done = 1'b0;         // cycle 17
    chk("edge_c17_stage", 16'(Stage), 16'd7);
    chk("edge_c17_done", 16'(Done), 16'd1);
    chk("edge_c17_err", 16'(Err), 16'd0);
    chk("edge_c17_job_cycles", Job_cycles, 16'd17);
    tick();
    chk("edge_idle_stage", 16'(Stage), 16'd0);

    // Reset for one cycle mid-TREE.
    Job_start = 1'b1; tick(); Job_start = 1'b0;      // cycle 1
    tick(); Cnt_done = 1'b1;                          // cycle 2
    tick(); Cnt_done = 1'b0;                          // cycle 3 TREE
    tick();                                           // cycle 4
    chk("mrst_pre_stage", 16'(Stage), 16'd2);
    n_Rst = 1'b0; tick(); n_Rst = 1'b1;
    chk("mrst_stage", 16'(Stage), 16'd0);
    chk("mrst_cg_rst_n", 16'(Cg_rst_n), 16'd0);
    chk("mrst_busy", 16'(Busy), 16'd0);
    chk("mrst_done", 16'(Done), 16'd0);
    chk("mrst_err", 16'(Err), 16'd0);
    chk("mrst_tree_start", 16'(Tree_start), 16'd0);
    chk("mrst_start_code", 16'(Start_code), 16'd0);
    chk("mrst_job_cycles", Job_cycles, 16'd0);
    tick();
    chk("mrst_rel_cg_rst_n", 16'(Cg_rst_n), 16'd1);
    chk("mrst_rel_stage", 16'(Stage), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
